// File: rtl/apb_master_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_master_bridge                                             |
// | Brief    : Single-outstanding request/response to APB master bridge      |
// |            with registered outputs and an ACCESS-phase wait timeout.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 32,
  parameter int PRDATA_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [PADDR_WIDTH-1:0]  req_addr,
  input  logic                    req_write,
  input  logic [PWDATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]              req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PRDATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [PADDR_WIDTH-1:0]  paddr,
  output logic                    prwd,
  output logic [PWDATA_WIDTH-1:0] pwdata,
  output logic [15:0]             psel,
  output logic                    penable,
  input  logic                    pready,
  input  logic [PRDATA_WIDTH-1:0] prdata,
  input  logic                    pslverr
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_last_wait =
      c_cnt_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic c_timeout_en = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               w_timeout_hit;

  // The current cycle is the last allowed wait; a pready in it still wins.
  assign w_timeout_hit = c_timeout_en && (r_wait_cnt == c_last_wait);

  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      prwd        <= 1'b0;
      pwdata      <= '0;
      psel        <= '0;
      penable     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            paddr      <= req_addr;
            prwd       <= req_write;
            pwdata     <= req_wdata;
            psel       <= 16'b1 << req_sel;
            req_ready  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            rsp_rdata   <= prwd ? '0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= '0;
            penable     <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            if (c_timeout_en) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout_hit) begin
              rsp_rdata   <= '0;
              rsp_slverr  <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              psel        <= '0;
              penable     <= 1'b0;
              r_state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be: PADDR_WIDTH, default 32, APB address width; PWDATA_WIDTH, default 32, write data width; PRDATA_WIDTH, default 32, read data width; TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles, where 0 disables the timeout.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be, in order:
- pclock  in  1  clock, all state on rising edge.
- preset  in  1  asynchronous active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high with req_valid.
- req_addr  in  PADDR_WIDTH  target address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  PWDATA_WIDTH  write data.
- req_sel  in  4  slave index 0..15.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  PRDATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  slave error or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  PADDR_WIDTH  APB address.
- prwd  out  1  APB direction, 1 = write.
- pwdata  out  PWDATA_WIDTH  APB write data.
- psel  out  16  one-hot slave select.
- penable  out  1  APB access phase.
- pready  in  1  slave ready.
- prdata  in  PRDATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Function
REQ-004 The FSM SHALL have exactly four states, IDLE, SETUP, ACCESS and RESP, and all outputs SHALL be registered.
REQ-005 IDLE: req_ready = 1. On req_valid & req_ready, the block SHALL capture addr/write/wdata/sel, drive paddr/prwd/pwdata, set psel = 1 << req_sel, and go to SETUP.
REQ-006 SETUP: lasts exactly one cycle with psel one-hot and penable = 0, then goes to ACCESS.
REQ-007 ACCESS: penable = 1. paddr, prwd, pwdata and psel SHALL remain unchanged from SETUP until exit.
REQ-008 ACCESS exit on pready = 1:
- rsp_rdata = prdata for reads, 0 for writes.
- rsp_slverr = pslverr, rsp_timeout = 0.
- On the next edge, psel = 0 and penable = 0; go to RESP.
REQ-009 A wait counter SHALL count ACCESS cycles with pready = 0 and clear on entering SETUP.
- When it reaches TIMEOUT_CYCLES (non-zero): abort with rsp_timeout = 1, rsp_slverr = 1, rsp_rdata = 0; drop psel/penable; go to RESP.
- The counter width SHALL hold TIMEOUT_CYCLES without wrap.
- If pready = 1 in the same cycle the limit is reached, normal completion SHALL win.
REQ-010 RESP: rsp_valid = 1 with rdata/slverr/timeout held stable until rsp_ready = 1. On that edge, rsp_valid drops and the FSM goes to IDLE.
REQ-011 req_ready SHALL be 0 in every state except IDLE; at most one transfer is outstanding.
REQ-012 Latency: request accepted at edge N -> SETUP (psel) at N+1 -> penable at N+2. With pready high at N+2, rsp_valid is high after edge N+3. Minimum is 4 cycles from acceptance to a response available.
REQ-013 In IDLE and RESP, paddr/prwd/pwdata SHALL hold their last driven values (never X); psel = 0 and penable = 0.
REQ-014 pslverr and prdata SHALL be ignored except in the ACCESS cycle where pready = 1.

Reset
REQ-015 While preset = 1, immediately and asynchronously: state = IDLE; psel, penable, paddr, prwd, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0; wait counter = 0.
REQ-016 req_ready SHALL be 0 while preset = 1 and 1 on the first edge after release.
REQ-017 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abandon the transfer without issuing a response; psel/penable drop in the same cycle preset rises.

Verification
REQ-018 Write, zero wait: sel = 3, addr = 0x10, wdata = 0xA5A5_0001, pready tied 1.
-> psel = 0x0008 for 2 cycles, penable for 1 cycle.
-> rsp_valid with rdata = 0, slverr = 0, 4 cycles after acceptance.
REQ-019 Read, 3 wait states: sel = 15, prdata = 0xDEAD_BEEF, pready high on the 4th ACCESS cycle.
-> psel = 0x8000 held for 5 cycles.
-> rsp_rdata = 0xDEAD_BEEF, slverr = 0.
REQ-020 Slave error: read with pslverr = 1 at pready.
-> rsp_slverr = 1, rsp_timeout = 0, rsp_rdata = prdata.
REQ-021 Timeout, TIMEOUT_CYCLES = 16, pready held 0.
-> abort after 16 ACCESS cycles; psel = 0 on the next edge.
-> rsp_timeout = 1, slverr = 1, rdata = 0.
-> With pready rising on exactly the 16th cycle instead: normal completion.
REQ-022 Backpressure and reset: hold rsp_ready = 0 for 5 cycles.
-> rsp fields stable, req_ready = 0.
-> Assert preset during ACCESS: psel, penable = 0 the same cycle, no rsp_valid; the next request completes normally.
